load_buf_dma: RTL and testbench

Parametrised load engine that replaces the single-shot load buffer. It accepts one load command per handshake and issues a single AXI4 INCR read burst. It streams the returned beats into the local SRAM with a programmable address stride, then reports completion and error status. It sits between the controller's command path and the AXI read master port / SRAM wrapper write port.

---
 rtl/load_buf_pkg.sv | 25 ++
 rtl/load_buf_addr_gen.sv | 39 +++
 rtl/load_buf_dffe.sv | 28 ++
 rtl/load_buf_dma.sv | 185 ++++++++++++++++++
 tb/tb_load_buf_dma.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_buf_pkg.sv
// +----------------------------------------------------------------------+
// | load_buf_pkg                                                         |
// | Shared state encoding and AXI constants for the load buffer DMA.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package load_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } load_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // One bit wider than arlen so beats past a 256-beat burst still count as overruns.
    localparam int unsigned BEAT_CNT_W = 9;

endpackage

`default_nettype wire

// File: rtl/load_buf_addr_gen.sv
// +----------------------------------------------------------------------+
// | load_buf_addr_gen                                                    |
// | SRAM write pointer: load start address, advance by stride, wrap.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module load_buf_addr_gen #(
    parameter int SRAM_AW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [SRAM_AW-1:0] i_load_addr,
    input  logic               i_step,
    input  logic [2:0]         i_stride_m1,
    output logic [SRAM_AW-1:0] o_ptr
);

    logic [SRAM_AW-1:0] w_stride;
    logic [SRAM_AW-1:0] w_ptr_nxt;

    // Modulo-2^SRAM_AW add gives the silent wrap for free.
    assign w_stride  = SRAM_AW'(i_stride_m1) + SRAM_AW'(1);
    assign w_ptr_nxt = i_load ? i_load_addr : (o_ptr + w_stride);

    load_buf_dffe #(
        .W (SRAM_AW)
    ) u_ptr_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (i_load | i_step),
        .i_d   (w_ptr_nxt),
        .o_q   (o_ptr)
    );

endmodule

`default_nettype wire

// File: rtl/load_buf_dffe.sv
// +----------------------------------------------------------------------+
// | load_buf_dffe                                                        |
// | Enabled D flip-flop bank with asynchronous active-low clear.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module load_buf_dffe #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/load_buf_dma.sv
// +----------------------------------------------------------------------+
// | load_buf_dma                                                         |
// | Single AXI4 INCR read burst per command, streamed into SRAM with a   |
// | programmable stride. Optional macro: LOAD_BUF_RESP_CHK_EN enables    |
// | per-beat RRESP/RID checking.                                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module load_buf_dma #(
    parameter int DATA_W  = 32,
    parameter int DRAM_AW = 12,
    parameter int SRAM_AW = 8,
    parameter int ID_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_vld,
    output logic                cmd_rdy,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic [DRAM_AW-1:0]  cmd_dram_addr,
    input  logic [7:0]          cmd_len,
    input  logic [2:0]          cmd_size,
    input  logic [2:0]          cmd_str,
    input  logic [SRAM_AW-1:0]  cmd_sram_addr,
    output logic [ID_W-1:0]     axi_arid,
    output logic [DRAM_AW-1:0]  axi_araddr,
    output logic [7:0]          axi_arlen,
    output logic [2:0]          axi_arsize,
    output logic [1:0]          axi_arburst,
    output logic                axi_arvalid,
    input  logic                axi_arready,
    input  logic [ID_W-1:0]     axi_rid,
    input  logic [DATA_W-1:0]   axi_rdata,
    input  logic [1:0]          axi_rresp,
    input  logic                axi_rlast,
    input  logic                axi_rvalid,
    output logic                axi_rready,
    output logic                sram_vld,
    output logic                sram_wen,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [DATA_W-1:0]   sram_din,
    output logic [DATA_W/8-1:0] sram_be,
    output logic                load_busy,
    output logic                load_done,
    output logic                load_err
);

    import load_buf_pkg::*;

    load_state_e           r_state;
    load_state_e           w_state_nxt;
    logic [ID_W-1:0]       r_id;
    logic [DRAM_AW-1:0]    r_araddr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [2:0]            r_str;
    logic [BEAT_CNT_W-1:0] r_cnt;
    logic                  r_err;
    logic                  r_wr_slot;
    logic                  r_wr_en;
    logic [DATA_W-1:0]     r_wr_data;
    logic [SRAM_AW-1:0]    w_ptr;
    logic                  w_cmd_fire;
    logic                  w_beat_fire;
    logic                  w_beat_over;
    logic                  w_beat_bad;

    assign w_cmd_fire  = cmd_vld && (r_state == ST_IDLE);
    assign w_beat_fire = axi_rvalid && (r_state == ST_DATA);
    assign w_beat_over = r_cnt > BEAT_CNT_W'(r_len);

`ifdef LOAD_BUF_RESP_CHK_EN
    assign w_beat_bad = (axi_rresp != AXI_RESP_OKAY) || (axi_rid != r_id);
`else
    logic w_unused_resp;
    assign w_unused_resp = ^{axi_rid, axi_rresp};
    assign w_beat_bad    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_id      <= '0;
            r_araddr  <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_str     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_wr_slot <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cmd_fire) begin
                r_id     <= cmd_id;
                r_araddr <= cmd_dram_addr;
                r_len    <= cmd_len;
                r_size   <= cmd_size;
                r_str    <= cmd_str;
                r_cnt    <= '0;
                r_err    <= 1'b0;
            end
            // A bad-response beat keeps its slot so the pointer stays aligned.
            r_wr_slot <= w_beat_fire && !w_beat_over;
            r_wr_en   <= w_beat_fire && !w_beat_over && !w_beat_bad;
            if (w_beat_fire) begin
                r_wr_data <= axi_rdata;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + BEAT_CNT_W'(1);
                end
                if (w_beat_over || w_beat_bad ||
                    (axi_rlast && (r_cnt != BEAT_CNT_W'(r_len)))) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_rdy     = 1'b0;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        load_busy   = 1'b1;
        load_done   = 1'b0;
        load_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_rdy   = 1'b1;
                load_busy = 1'b0;
                if (cmd_vld) begin
                    w_state_nxt = ST_AR;
                end
            end
            ST_AR: begin
                axi_arvalid = 1'b1;
                if (axi_arready) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                axi_rready = 1'b1;
                if (axi_rvalid && axi_rlast) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                load_done   = 1'b1;
                load_err    = r_err;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    load_buf_addr_gen #(
        .SRAM_AW (SRAM_AW)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_cmd_fire),
        .i_load_addr (cmd_sram_addr),
        .i_step      (r_wr_slot),
        .i_stride_m1 (r_str),
        .o_ptr       (w_ptr)
    );

    assign axi_arid    = r_id;
    assign axi_araddr  = r_araddr;
    assign axi_arlen   = r_len;
    assign axi_arsize  = r_size;
    assign axi_arburst = AXI_BURST_INCR;
    assign sram_vld    = r_wr_en;
    assign sram_wen    = r_wr_en;
    assign sram_addr   = w_ptr;
    assign sram_din    = r_wr_data;
    assign sram_be     = '1;

endmodule

`default_nettype wire

// File: tb/tb_load_buf_dma.sv
// +----------------------------------------------------------------------+
// | tb_load_buf_dma                                                      |
// | Self-checking bench: directed table, hand sequences, random loads.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_load_buf_dma;

    localparam int DATA_W  = 32;
    localparam int DRAM_AW = 12;
    localparam int SRAM_AW = 8;
    localparam int ID_W    = 8;
`ifdef LOAD_BUF_RESP_CHK_EN
    localparam bit RESP_CHK = 1'b1;
`else
    localparam bit RESP_CHK = 1'b0;
`endif

    logic                clk;
    logic                rst_n;
    logic                cmd_vld;
    logic                cmd_rdy;
    logic [ID_W-1:0]     cmd_id;
    logic [DRAM_AW-1:0]  cmd_dram_addr;
    logic [7:0]          cmd_len;
    logic [2:0]          cmd_size;
    logic [2:0]          cmd_str;
    logic [SRAM_AW-1:0]  cmd_sram_addr;
    logic [ID_W-1:0]     axi_arid;
    logic [DRAM_AW-1:0]  axi_araddr;
    logic [7:0]          axi_arlen;
    logic [2:0]          axi_arsize;
    logic [1:0]          axi_arburst;
    logic                axi_arvalid;
    logic                axi_arready;
    logic [ID_W-1:0]     axi_rid;
    logic [DATA_W-1:0]   axi_rdata;
    logic [1:0]          axi_rresp;
    logic                axi_rlast;
    logic                axi_rvalid;
    logic                axi_rready;
    logic                sram_vld;
    logic                sram_wen;
    logic [SRAM_AW-1:0]  sram_addr;
    logic [DATA_W-1:0]   sram_din;
    logic [DATA_W/8-1:0] sram_be;
    logic                load_busy;
    logic                load_done;
    logic                load_err;

    load_buf_dma #(
        .DATA_W  (DATA_W),
        .DRAM_AW (DRAM_AW),
        .SRAM_AW (SRAM_AW),
        .ID_W    (ID_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_vld       (cmd_vld),
        .cmd_rdy       (cmd_rdy),
        .cmd_id        (cmd_id),
        .cmd_dram_addr (cmd_dram_addr),
        .cmd_len       (cmd_len),
        .cmd_size      (cmd_size),
        .cmd_str       (cmd_str),
        .cmd_sram_addr (cmd_sram_addr),
        .axi_arid      (axi_arid),
        .axi_araddr    (axi_araddr),
        .axi_arlen     (axi_arlen),
        .axi_arsize    (axi_arsize),
        .axi_arburst   (axi_arburst),
        .axi_arvalid   (axi_arvalid),
        .axi_arready   (axi_arready),
        .axi_rid       (axi_rid),
        .axi_rdata     (axi_rdata),
        .axi_rresp     (axi_rresp),
        .axi_rlast     (axi_rlast),
        .axi_rvalid    (axi_rvalid),
        .axi_rready    (axi_rready),
        .sram_vld      (sram_vld),
        .sram_wen      (sram_wen),
        .sram_addr     (sram_addr),
        .sram_din      (sram_din),
        .sram_be       (sram_be),
        .load_busy     (load_busy),
        .load_done     (load_done),
        .load_err      (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observed SRAM writes and completion pulses, sampled mid-cycle.
    typedef struct packed {
        logic [SRAM_AW-1:0] addr;
        logic [DATA_W-1:0]  data;
    } wr_t;

    wr_t  wr_q[$];
    int   done_cnt = 0;
    logic done_err = 1'b0;

    always @(negedge clk) begin
        if (sram_vld && sram_wen) wr_q.push_back({sram_addr, sram_din});
        if (load_done) begin
            done_cnt <= done_cnt + 1;
            done_err <= load_err;
        end
    end

    // One full load: command, AR phase, R beats, completion; compared to a plain model.
    task automatic run_load(input logic [7:0] len, input logic [2:0] str, input logic [7:0] sa,
                            input int nbeats, input int bad_idx, input bit bad_rid,
                            input int ar_delay, input int gap_max, input logic [31:0] base,
                            output int got_nwr, output logic got_err);
        wr_t               exp_q[$];
        logic              exp_err;
        int                wr_base;
        int                done_base;
        logic [ID_W-1:0]   id;
        logic [DRAM_AW-1:0] daddr;
        logic [2:0]        sz;

        for (int i = 0; i < nbeats; i++) begin
            if (i <= int'(len) && !(RESP_CHK && i == bad_idx))
                exp_q.push_back({8'(int'(sa) + i * (int'(str) + 1)), base + 32'(i)});
        end
        exp_err = (nbeats != int'(len) + 1) || (RESP_CHK && bad_idx >= 0 && bad_idx < nbeats);

        id    = ID_W'($urandom);
        daddr = DRAM_AW'($urandom);
        sz    = 3'($urandom);
        wr_base   = wr_q.size();
        done_base = done_cnt;

        @(negedge clk);
        chk("cmd_rdy_idle", cmd_rdy, 1);
        cmd_vld = 1; cmd_id = id; cmd_dram_addr = daddr; cmd_len = len;
        cmd_size = sz; cmd_str = str; cmd_sram_addr = sa;
        @(negedge clk);
        cmd_vld = 0;
        chk("arvalid", axi_arvalid, 1);
        chk("araddr", axi_araddr, daddr);
        chk("arlen", axi_arlen, len);
        chk("arid", axi_arid, id);
        chk("arsize", axi_arsize, sz);
        chk("arburst", axi_arburst, 2'b01);
        chk("busy_ar", load_busy, 1);
        chk("cmd_rdy_ar", cmd_rdy, 0);

        for (int k = 0; k < ar_delay; k++) begin
            axi_arready = 0;
            cmd_vld = 1; cmd_dram_addr = ~daddr; cmd_len = ~len;
            axi_rvalid = 1; axi_rlast = 1; axi_rdata = 32'hDEAD_0000;
            @(negedge clk);
            cmd_vld = 0;
            chk("arvalid_hold", axi_arvalid, 1);
            chk("araddr_hold", axi_araddr, daddr);
            chk("arlen_hold", axi_arlen, len);
            chk("rready_ar", axi_rready, 0);
            chk("cmd_rdy_hold", cmd_rdy, 0);
        end
        axi_rvalid = 0; axi_rlast = 0;
        axi_arready = 1;
        @(negedge clk);
        axi_arready = 0;

        for (int i = 0; i < nbeats; i++) begin
            repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            chk("rready_data", axi_rready, 1);
            axi_rvalid = 1;
            axi_rdata  = base + 32'(i);
            axi_rlast  = (i == nbeats - 1);
            axi_rresp  = (i == bad_idx && !bad_rid) ? 2'b10 : 2'b00;
            axi_rid    = (i == bad_idx && bad_rid) ? ~id : id;
            @(negedge clk);
            axi_rvalid = 0; axi_rlast = 0; axi_rresp = 2'b00;
        end
        chk("load_done", load_done, 1);
        chk("load_err", load_err, exp_err);
        chk("sram_be", sram_be, 4'hF);
        @(negedge clk);
        chk("cmd_rdy_after", cmd_rdy, 1);
        chk("done_single_cycle", load_done, 0);
        chk("busy_after", load_busy, 0);
        chk("done_count", done_cnt - done_base, 1);
        chk("done_err_seen", done_err, exp_err);

        got_nwr = wr_q.size() - wr_base;
        got_err = done_err;
        chk("wr_count", got_nwr, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_nwr; i++) begin
            chk("wr_addr", wr_q[wr_base + i].addr, exp_q[i].addr);
            chk("wr_data", wr_q[wr_base + i].data, exp_q[i].data);
        end
    endtask

    typedef struct {
        logic [7:0]  len;
        logic [2:0]  str;
        logic [7:0]  sa;
        int          nbeats;
        int          bad_idx;
        int          ar_delay;
        logic [31:0] base;
        int          exp_nwr;
        logic        exp_err;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int   nwr;
        logic err;
        int   wr_base;
        int   done_base;

        tbl[0] = '{8'd3,   3'd0, 8'h10, 4,   -1, 0, 32'hA0,  4,   1'b0}; // basic
        tbl[1] = '{8'd2,   3'd2, 8'hFE, 3,   -1, 0, 32'h100, 3,   1'b0}; // stride + wrap
        tbl[2] = '{8'd1,   3'd1, 8'h20, 2,   -1, 5, 32'h200, 2,   1'b0}; // AR backpressure
        tbl[3] = '{8'd3,   3'd0, 8'h30, 2,   -1, 0, 32'h300, 2,   1'b1}; // early rlast
        tbl[4] = '{8'd1,   3'd0, 8'h40, 3,   -1, 0, 32'h400, 2,   1'b1}; // late rlast
        tbl[5] = '{8'd3,   3'd0, 8'h50, 4,    1, 0, 32'h500,
                   RESP_CHK ? 3 : 4, RESP_CHK};                          // bad rresp
        tbl[6] = '{8'd0,   3'd7, 8'h60, 1,   -1, 0, 32'h600, 1,   1'b0}; // single beat
        tbl[7] = '{8'd255, 3'd7, 8'h00, 256, -1, 0, 32'h700, 256, 1'b0}; // max burst

        rst_n = 0; cmd_vld = 0; cmd_id = '0; cmd_dram_addr = '0; cmd_len = '0;
        cmd_size = '0; cmd_str = '0; cmd_sram_addr = '0; axi_arready = 0;
        axi_rid = '0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 0; axi_rvalid = 0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_rdy", cmd_rdy, 1);
        chk("rst_arvalid", axi_arvalid, 0);
        chk("rst_araddr", axi_araddr, 0);
        chk("rst_rready", axi_rready, 0);
        chk("rst_sram_vld", sram_vld, 0);
        chk("rst_busy", load_busy, 0);
        chk("rst_done", load_done, 0);
        chk("rst_arburst", axi_arburst, 2'b01);
        rst_n = 1;
        @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            run_load(tbl[t].len, tbl[t].str, tbl[t].sa, tbl[t].nbeats, tbl[t].bad_idx, 1'b0,
                     tbl[t].ar_delay, (t == 0) ? 0 : 1, tbl[t].base, nwr, err);
            chk($sformatf("tbl%0d_nwr", t), nwr, tbl[t].exp_nwr);
            chk($sformatf("tbl%0d_err", t), err, tbl[t].exp_err);
        end
        chk("wrap_addr1", wr_q[5].addr, 8'h01);
        chk("wrap_addr2", wr_q[6].addr, 8'h04);

        // Reset in the middle of a burst.
        wr_base   = wr_q.size();
        done_base = done_cnt;
        @(negedge clk);
        cmd_vld = 1; cmd_len = 8'd3; cmd_str = 3'd0; cmd_sram_addr = 8'h70; cmd_dram_addr = 12'h123;
        @(negedge clk);
        cmd_vld = 0; axi_arready = 1;
        @(negedge clk);
        axi_arready = 0; axi_rvalid = 1; axi_rdata = 32'hB0;
        @(negedge clk);
        axi_rdata = 32'hB1;
        @(negedge clk);
        axi_rvalid = 0;
        #2 rst_n = 0;
        #1;
        chk("mid_rst_cmd_rdy", cmd_rdy, 1);
        chk("mid_rst_busy", load_busy, 0);
        chk("mid_rst_rready", axi_rready, 0);
        chk("mid_rst_sram_vld", sram_vld, 0);
        chk("mid_rst_sram_addr", sram_addr, 0);
        chk("mid_rst_araddr", axi_araddr, 0);
        chk("mid_rst_done", load_done, 0);
        chk("mid_rst_pre_writes", wr_q.size() - wr_base, 2);
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        chk("mid_rst_no_done", done_cnt - done_base, 0);
        run_load(8'd3, 3'd1, 8'h80, 4, -1, 1'b0, 1, 1, 32'hC0, nwr, err);
        chk("post_rst_nwr", nwr, 4);
        chk("post_rst_err", err, 0);

        // Randomized loads against the model inside run_load.
        for (int r = 0; r < 40; r++) begin
            logic [7:0] len;
            int nb;
            int bad;
            len = 8'($urandom_range(15, 0));
            nb  = ($urandom_range(9, 0) < 7) ? int'(len) + 1 : $urandom_range(int'(len) + 3, 1);
            bad = ($urandom_range(4, 0) == 0) ? $urandom_range(nb - 1, 0) : -1;
            run_load(len, 3'($urandom), 8'($urandom), nb, bad, 1'($urandom),
                     $urandom_range(3, 0), 2, $urandom, nwr, err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
